lcd_stream_ctrl: RTL and testbench

//  Parametrised HD44780 4-bit LCD controller. Accepts a byte stream (chars and raw commands) over a

---
 rtl/lcd_stream_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_lcd_stream_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_stream_ctrl.sv
// HD44780 4-bit LCD controller: byte stream in, power-on init, cursor tracking,
// automatic set-DDRAM-address insertion after wraps/newlines, divider-paced bus.
module lcd_stream_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int ROWS      = 2,
  parameter int COLS      = 16,
  parameter int GAP_SLOTS = 2,
  parameter int CLR_SLOTS = 40
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_cmd,
  output logic       in_ready,
  output logic       busy,
  output logic [1:0] cur_row,
  output logic [5:0] cur_col,
  output logic       LCD_RS,
  output logic       LCD_E,
  output logic [3:0] LCD_D
);
  localparam int SLOT = 2 * CLK_DIV;
  localparam int CW   = $clog2(SLOT);
  localparam int GMAX = (CLR_SLOTS > GAP_SLOTS) ? CLR_SLOTS : GAP_SLOTS;
  localparam int GW   = $clog2(GMAX + 1);

  typedef enum logic [2:0] {INIT, IDLE, ADDR_HI, ADDR_LO, BYTE_HI, BYTE_LO, GAP, NEWLINE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt, gap_load;
  logic [3:0]    init_step;
  logic [7:0]    tx_byte, addr_byte;
  logic          tx_rs, addr_phase, addr_pending;
  logic          slot_end, gap_done, accept, drive, e_nxt, rs_nxt;
  logic [3:0]    d_nxt;
  logic [1:0]    row_inc;

  function automatic logic [7:0] init_byte(input logic [3:0] s);
    case (s)
      4'd4:    init_byte = (ROWS == 1) ? 8'h20 : 8'h28;
      4'd5:    init_byte = 8'h0C;
      4'd6:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    row_base = 8'h00;
      2'd1:    row_base = 8'h40;
      2'd2:    row_base = 8'(COLS);
      default: row_base = 8'(64 + COLS);
    endcase
  endfunction

  assign slot_end = (cnt == CW'(SLOT - 1));
  assign gap_done = slot_end && (gap_cnt == GW'(1));
  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid && in_ready;
  assign row_inc  = (cur_row == 2'(ROWS - 1)) ? 2'd0 : cur_row + 2'd1;

  always_comb begin
    state_nxt = state;
    gap_load  = GW'(GAP_SLOTS);
    drive     = 1'b0;
    rs_nxt    = 1'b0;
    d_nxt     = 4'h0;
    case (state)
      INIT: begin
        drive = 1'b1;
        d_nxt = (init_step == 4'd3) ? 4'h2 : 4'h3;
        if (slot_end) state_nxt = GAP;
      end
      IDLE: if (accept) begin
        if (in_cmd)                 state_nxt = BYTE_HI;
        else if (in_data == 8'h0A)  state_nxt = NEWLINE;
        else if (addr_pending)      state_nxt = ADDR_HI;
        else                        state_nxt = BYTE_HI;
      end
      ADDR_HI: begin
        drive = 1'b1;
        d_nxt = addr_byte[7:4];
        if (slot_end) state_nxt = ADDR_LO;
      end
      ADDR_LO: begin
        drive = 1'b1;
        d_nxt = addr_byte[3:0];
        if (slot_end) state_nxt = GAP;
      end
      BYTE_HI: begin
        drive  = 1'b1;
        rs_nxt = tx_rs;
        d_nxt  = tx_byte[7:4];
        if (slot_end) state_nxt = BYTE_LO;
      end
      BYTE_LO: begin
        drive  = 1'b1;
        rs_nxt = tx_rs;
        d_nxt  = tx_byte[3:0];
        if (!tx_rs && (tx_byte == 8'h01 || tx_byte == 8'h02)) gap_load = GW'(CLR_SLOTS);
        if (slot_end) state_nxt = GAP;
      end
      GAP: if (gap_done) begin
        if (init_step != 4'd8)
          state_nxt = (init_step < 4'd3) ? INIT : (init_step == 4'd7) ? IDLE : BYTE_HI;
        else
          state_nxt = addr_phase ? BYTE_HI : IDLE;
      end
      NEWLINE: state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
    e_nxt = drive && (cnt >= CW'(1)) && (cnt <= CW'(CLK_DIV));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= INIT;
      cnt          <= '0;
      gap_cnt      <= '0;
      init_step    <= '0;
      tx_byte      <= '0;
      tx_rs        <= 1'b0;
      addr_byte    <= '0;
      addr_phase   <= 1'b0;
      addr_pending <= 1'b0;
      cur_row      <= '0;
      cur_col      <= '0;
    end else begin
      state <= state_nxt;
      if (state != IDLE && state != NEWLINE) cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end && (state == INIT || state == ADDR_LO || state == BYTE_LO)) gap_cnt <= gap_load;
      else if (slot_end && state == GAP) gap_cnt <= gap_cnt - GW'(1);
      if (slot_end && state == ADDR_LO) addr_phase <= 1'b1;

      // End of a byte's gap: advance init, release the char held behind an address, or retire the byte
      if (state == GAP && gap_done) begin
        if (init_step != 4'd8) begin
          init_step <= init_step + 4'd1;
          tx_byte   <= init_byte(init_step + 4'd1);
          tx_rs     <= 1'b0;
        end else if (addr_phase) begin
          addr_phase <= 1'b0;
        end else if (tx_rs) begin
          if (cur_col == 6'(COLS - 1)) begin
            cur_col      <= '0;
            cur_row      <= row_inc;
            addr_pending <= 1'b1;
          end else begin
            cur_col <= cur_col + 6'd1;
          end
        end else if (tx_byte == 8'h01 || tx_byte == 8'h02) begin
          cur_row      <= '0;
          cur_col      <= '0;
          addr_pending <= 1'b0;
        end else if (tx_byte[7]) begin
          addr_pending <= 1'b1;
        end
      end

      if (accept) begin
        if (in_cmd) begin
          tx_byte <= in_data;
          tx_rs   <= 1'b0;
        end else if (in_data == 8'h0A) begin
          cur_col      <= '0;
          cur_row      <= row_inc;
          addr_pending <= 1'b1;
        end else begin
          tx_byte <= in_data;
          tx_rs   <= 1'b1;
          if (addr_pending) begin
            addr_byte    <= 8'h80 | (row_base(cur_row) + {2'b00, cur_col});
            addr_pending <= 1'b0;
          end
        end
      end
    end
  end

  // Pins are registered so E/RS/D never glitch; RS/D hold their last value through gaps
  always_ff @(posedge CLK) begin
    if (RST) begin
      LCD_E  <= 1'b0;
      LCD_RS <= 1'b0;
      LCD_D  <= 4'h0;
    end else begin
      LCD_E <= e_nxt;
      if (drive) begin
        LCD_RS <= rs_nxt;
        LCD_D  <= d_nxt;
      end
    end
  end
endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// Bench for lcd_stream_ctrl: init sequence, directed vectors, reset mid-byte,
// and random byte streams against a cursor/bus reference model.
module tb_lcd_stream_ctrl;
  localparam int CLK_DIV = 4, ROWS = 2, COLS = 16, GAP = 2, CLR = 40;
  localparam int SLOT = 2 * CLK_DIV;

  logic       CLK = 1'b0, RST = 1'b1;
  logic       in_valid = 1'b0, in_cmd = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, busy, LCD_RS, LCD_E;
  logic [1:0] cur_row;
  logic [5:0] cur_col;
  logic [3:0] LCD_D;

  lcd_stream_ctrl #(.CLK_DIV(CLK_DIV), .ROWS(ROWS), .COLS(COLS), .GAP_SLOTS(GAP), .CLR_SLOTS(CLR)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_cmd(in_cmd),
    .in_ready(in_ready), .busy(busy), .cur_row(cur_row), .cur_col(cur_col),
    .LCD_RS(LCD_RS), .LCD_E(LCD_E), .LCD_D(LCD_D));

  always #5 CLK = ~CLK;

  typedef struct {
    bit         cmd;
    logic [7:0] data;
    int         nn;
    logic [19:0] nibs;
    int         busy;
    int         row;
    int         col;
  } vec_t;

  int errors = 0, checks = 0;
  int cyc = 0;
  logic [4:0] nib_q[$], exp_q[$];
  int rise_q[$];
  bit e_prev = 1'b0;
  int e_w = 0, width_err = 0, n_pulse = 0;
  int init_slot[12];
  logic [4:0] init_nib[12];
  int m_row, m_col;
  bit m_pend;

  always @(posedge CLK) cyc <= cyc + 1;

  // Bus monitor: one entry per E pulse, plus its high width
  always @(posedge CLK) begin
    #1;
    if (LCD_E && !e_prev) begin
      nib_q.push_back({LCD_RS, LCD_D});
      rise_q.push_back(cyc);
      e_w = 1;
    end else if (LCD_E) begin
      e_w++;
    end else if (e_prev && !RST) begin
      n_pulse++;
      if (e_w != CLK_DIV) width_err++;
    end
    e_prev = LCD_E;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cmp_nibs(input string name);
    int bad = -1;
    checks++;
    for (int k = 0; k < exp_q.size() && k < nib_q.size(); k++)
      if (bad < 0 && nib_q[k] !== exp_q[k]) bad = k;
    if (nib_q.size() != exp_q.size() || bad >= 0) begin
      errors++;
      if (bad >= 0)
        $display("FAIL %s: nibble %0d got {rs,d}=0x%0h expected 0x%0h (count got %0d expected %0d)",
                 name, bad, nib_q[bad], exp_q[bad], nib_q.size(), exp_q.size());
      else
        $display("FAIL %s: nibble count got %0d expected %0d", name, nib_q.size(), exp_q.size());
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 2000) begin @(negedge CLK); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL %s: in_ready got 0 after %0d cycles, expected 1", name, n);
    end
  endtask

  // Offer one byte, then check busy length, cursor and emitted nibbles (exp_q prefilled)
  task automatic do_send(input bit cmd, input logic [7:0] data, input int ebusy, input int erow, input int ecol);
    int lowc = 0;
    wait_ready("ready_before_send");
    nib_q.delete();
    in_valid = 1'b1; in_data = data; in_cmd = cmd;
    @(posedge CLK); #1;
    in_valid = 1'b0; in_data = 8'($urandom); in_cmd = 1'($urandom);
    @(negedge CLK);
    while (!in_ready && lowc < 5000) begin lowc++; @(negedge CLK); end
    check($sformatf("busy_cycles[%0h]", data), lowc, ebusy);
    check("busy_is_not_ready", int'(busy), 0);
    check($sformatf("cur_row[%0h]", data), int'(cur_row), erow);
    check($sformatf("cur_col[%0h]", data), int'(cur_col), ecol);
    cmp_nibs($sformatf("nibbles[%0h]", data));
  endtask

  // Called with RST high; releases it and checks the whole power-on sequence
  task automatic init_check(input string tag);
    int t0, n, bad;
    @(negedge CLK);
    RST = 1'b0; t0 = cyc;
    nib_q.delete(); rise_q.delete();
    n = 0;
    while (!in_ready && n < 2000) begin @(negedge CLK); n++; end
    check({tag, "_ready_time"}, cyc - t0, 528);
    exp_q.delete();
    for (int k = 0; k < 12; k++) exp_q.push_back(init_nib[k]);
    cmp_nibs({tag, "_nibbles"});
    if (rise_q.size() > 0)
      check({tag, "_first_e_in_window"}, int'((rise_q[0] - t0) >= 1 && (rise_q[0] - t0) <= 2), 1);
    bad = 0;
    for (int k = 0; k < 12 && k < rise_q.size(); k++)
      if (rise_q[k] - rise_q[0] != SLOT * init_slot[k]) bad++;
    check({tag, "_slot_spacing_errs"}, bad, 0);
  endtask

  task automatic push_byte(input bit rs, input logic [7:0] d);
    exp_q.push_back({rs, d[7:4]});
    exp_q.push_back({rs, d[3:0]});
  endtask

  // Reference: what one input byte should put on the bus, how long it blocks, where the cursor goes
  task automatic model(input bit cmd, input logic [7:0] d, output int bsy);
    int slots = 0, base;
    exp_q.delete();
    if (cmd) begin
      push_byte(1'b0, d);
      if (d == 8'h01 || d == 8'h02) begin
        slots = 2 + CLR; m_row = 0; m_col = 0; m_pend = 0;
      end else begin
        slots = 2 + GAP;
        if (d >= 8'h80) m_pend = 1;
      end
      bsy = slots * SLOT;
    end else if (d == 8'h0A) begin
      m_col = 0; m_row = (m_row + 1) % ROWS; m_pend = 1;
      bsy = 1;
    end else begin
      if (m_pend) begin
        base = (m_row == 0) ? 0 : (m_row == 1) ? 'h40 : (m_row == 2) ? COLS : 'h40 + COLS;
        push_byte(1'b0, 8'h80 | 8'(base + m_col));
        slots += 2 + GAP;
        m_pend = 0;
      end
      push_byte(1'b1, d);
      slots += 2 + GAP;
      m_col++;
      if (m_col == COLS) begin m_col = 0; m_row = (m_row + 1) % ROWS; m_pend = 1; end
      bsy = slots * SLOT;
    end
  endtask

  function automatic vec_t mk(input bit c, input logic [7:0] d, input int nn, input logic [19:0] nb,
                              input int b, input int r, input int co);
    vec_t v;
    v.cmd = c; v.data = d; v.nn = nn; v.nibs = nb; v.busy = b; v.row = r; v.col = co;
    return v;
  endfunction

  initial begin
    vec_t vt[$];
    vec_t v;
    int r, bsy, n;
    logic [7:0] d;
    bit c;

    init_slot = '{0, 3, 6, 9, 12, 13, 16, 17, 20, 21, 24, 25};
    init_nib  = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h0C, 5'h00, 5'h06, 5'h00, 5'h01};

    vt.push_back(mk(0, 8'h41, 2, {5'h14, 5'h11, 10'h0}, 32, 0, 1));
    for (int i = 1; i <= 15; i++)
      vt.push_back(mk(0, 8'(8'h60 + i), 2, {5'h16, 1'b1, 4'(i), 10'h0}, 32,
                      (i == 15) ? 1 : 0, (i == 15) ? 0 : i + 1));
    vt.push_back(mk(0, 8'h42, 4, {5'h0C, 5'h00, 5'h14, 5'h12}, 64, 1, 1));
    vt.push_back(mk(0, 8'h0A, 0, 20'h0, 1, 0, 0));
    vt.push_back(mk(0, 8'h43, 4, {5'h08, 5'h00, 5'h14, 5'h13}, 64, 0, 1));
    vt.push_back(mk(0, 8'h41, 2, {5'h14, 5'h11, 10'h0}, 32, 0, 2));
    vt.push_back(mk(1, 8'h01, 2, {5'h00, 5'h01, 10'h0}, 336, 0, 0));
    vt.push_back(mk(1, 8'h0E, 2, {5'h00, 5'h0E, 10'h0}, 32, 0, 0));
    vt.push_back(mk(0, 8'h30, 2, {5'h13, 5'h10, 10'h0}, 32, 0, 1));
    vt.push_back(mk(1, 8'hC5, 2, {5'h0C, 5'h05, 10'h0}, 32, 0, 1));
    vt.push_back(mk(0, 8'h31, 4, {5'h08, 5'h01, 5'h13, 5'h11}, 64, 0, 2));
    vt.push_back(mk(1, 8'h02, 2, {5'h00, 5'h02, 10'h0}, 336, 0, 0));

    repeat (3) @(negedge CLK);
    check("reset_pins", int'({LCD_E, LCD_RS, LCD_D}), 0);
    check("reset_ready", int'(in_ready), 0);
    check("reset_cursor", int'({cur_row, cur_col}), 0);
    init_check("init");

    foreach (vt[i]) begin
      v = vt[i];
      exp_q.delete();
      for (int k = 0; k < v.nn; k++) exp_q.push_back(v.nibs[19 - 5*k -: 5]);
      do_send(v.cmd, v.data, v.busy, v.row, v.col);
    end

    // Reset while the low nibble of a char is strobing
    exp_q.delete(); push_byte(1'b1, 8'h58);
    do_send(0, 8'h58, 32, 0, 1);
    wait_ready("ready_before_rst");
    nib_q.delete();
    in_valid = 1'b1; in_data = 8'h59; in_cmd = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n = 0;
    while (!(nib_q.size() >= 2 && LCD_E) && n < 200) begin @(negedge CLK); n++; end
    check("rst_mid_e_high", int'(LCD_E), 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("rst_mid_e_drop", int'(LCD_E), 0);
    check("rst_mid_ready", int'(in_ready), 0);
    check("rst_mid_cursor", int'({cur_row, cur_col}), 0);
    repeat (2) @(negedge CLK);
    init_check("reinit");

    m_row = 0; m_col = 0; m_pend = 0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      begin c = 0; d = 8'h0A; end
      else if (r < 13) begin c = 1; d = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02; end
      else if (r < 21) begin c = 1; d = 8'h80 | 8'($urandom_range(0, 127)); end
      else if (r < 27) begin c = 1; d = 8'(8'h04 + $urandom_range(0, 15)); end
      else             begin c = 0; d = 8'($urandom_range(8'h20, 8'h7E)); end
      model(c, d, bsy);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      do_send(c, d, bsy, m_row, m_col);
    end

    check("e_width_errors", width_err, 0);
    check("e_pulses_seen", int'(n_pulse > 100), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
